// File: rtl/expansion_shiftreg_pkg.sv
// Shared definitions for the expansion shift-register link (master and target).
// Holds the default frame width, synchroniser depth, bit counter sizing helper
// and the event encoding used by the target's control logic.
package expansion_shiftreg_pkg;

  localparam int DEFAULT_WIDTH       = 8;
  localparam int DEFAULT_SYNC_STAGES = 2;

  // Bit counter must hold 0..WIDTH+1 (WIDTH+1 marks an overflowed frame).
  function automatic int cnt_width(input int width);
    return $clog2(width + 2);
  endfunction

  localparam int DEFAULT_CNT_W = cnt_width(DEFAULT_WIDTH);

  // Link activity seen in one clk cycle after synchronisation.
  typedef enum logic [1:0] {
    EV_NONE,
    EV_LOAD,
    EV_SHIFT
  } link_event_e;

endpackage

// File: rtl/expansion_shiftreg_target_if.sv
// Serial wires of the expansion shift-register link.
//   master modport : drives SHIFT_CLK, SHIFT_LOAD, SHIFT_DIN; reads SHIFT_DOUT
//   slave modport  : reads SHIFT_CLK, SHIFT_LOAD, SHIFT_DIN; drives SHIFT_DOUT
// SHIFT_LOAD idles high; SHIFT_CLK idles low.
interface expansion_shiftreg_target_if;

  logic SHIFT_CLK;
  logic SHIFT_LOAD;
  logic SHIFT_DIN;
  logic SHIFT_DOUT;

  modport master (
    output SHIFT_CLK,
    output SHIFT_LOAD,
    output SHIFT_DIN,
    input  SHIFT_DOUT
  );

  modport slave (
    input  SHIFT_CLK,
    input  SHIFT_LOAD,
    input  SHIFT_DIN,
    output SHIFT_DOUT
  );

endinterface

// File: rtl/expansion_shiftreg_target_sync_edge.sv
// Multi-flop synchroniser for one asynchronous input plus edge detection.
//   clk, rst_n : local clock, async active-low reset
//   async_i    : asynchronous input
//   sync_o     : synchronised level (last synchroniser stage)
//   rise_o     : one-cycle pulse on a synchronised rising edge
//   fall_o     : one-cycle pulse on a synchronised falling edge
// RESET_VAL sets the reset level of every stage and of the edge-detect copy,
// so an input sitting at its idle level produces no edge after reset.
module shiftreg_sync_edge #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_i,
  output logic sync_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic              last_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbour; blocking here would collapse the chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {STAGES{RESET_VAL}};
      last_q <= RESET_VAL;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], async_i};
      last_q <= sync_q[STAGES-1];
    end
  end

  assign sync_o = sync_q[STAGES-1];
  assign rise_o = sync_q[STAGES-1] & ~last_q;
  assign fall_o = ~sync_q[STAGES-1] & last_q;

endmodule

// File: rtl/expansion_shiftreg_target.sv
// FPGA-side target of the expansion shift-register link. Emulates a
// 74HC595/74HC165 chain: bits from the master are shifted into rx_sr and
// presented on data_out at each load; data_in is captured at load and shifted
// back to the master MSB first on SHIFT_DOUT.
//   clk, rst_n  : local clock, async active-low reset
//   link        : serial link (slave side): SHIFT_CLK/LOAD/DIN in, SHIFT_DOUT out
//   data_in     : parallel word returned to the master, captured at load
//   data_out    : last complete word received from the master
//   frame_valid : one-cycle pulse when data_out updates
//   frame_error : one-cycle pulse when a load ends a frame of wrong length
module expansion_shiftreg_target
  import expansion_shiftreg_pkg::*;
#(
  parameter int WIDTH       = DEFAULT_WIDTH,
  parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
  input  logic                          clk,
  input  logic                          rst_n,
  expansion_shiftreg_target_if.slave    link,
  input  logic [WIDTH-1:0]              data_in,
  output logic [WIDTH-1:0]              data_out,
  output logic                          frame_valid,
  output logic                          frame_error
);

  localparam int               CNT_W    = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(WIDTH + 1);

  // Synchronised link inputs. LOAD idles high, so its chain resets high.
  logic clk_sync_unused, clk_rise, clk_fall_unused;
  logic load_sync, load_rise_unused, load_fall;
  logic din_sync, din_rise_unused, din_fall_unused;

  shiftreg_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_clk (
    .clk     (clk),
    .rst_n   (rst_n),
    .async_i (link.SHIFT_CLK),
    .sync_o  (clk_sync_unused),
    .rise_o  (clk_rise),
    .fall_o  (clk_fall_unused)
  );

  shiftreg_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_load (
    .clk     (clk),
    .rst_n   (rst_n),
    .async_i (link.SHIFT_LOAD),
    .sync_o  (load_sync),
    .rise_o  (load_rise_unused),
    .fall_o  (load_fall)
  );

  // DIN goes through the same depth as CLK, so din_sync at a synced CLK rise
  // is the value DIN held at the master's rising edge.
  shiftreg_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_din (
    .clk     (clk),
    .rst_n   (rst_n),
    .async_i (link.SHIFT_DIN),
    .sync_o  (din_sync),
    .rise_o  (din_rise_unused),
    .fall_o  (din_fall_unused)
  );

  logic [WIDTH-1:0] rx_q, rx_d;
  logic [WIDTH-1:0] tx_q, tx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] data_out_q, data_out_d;
  logic             valid_q, valid_d;
  logic             error_q, error_d;
  link_event_e      ev;

  always_comb begin
    // NOTE: every signal written here gets a default first; a path that leaves
    // one unassigned would infer a latch.
    ev         = EV_NONE;
    rx_d       = rx_q;
    tx_d       = tx_q;
    cnt_d      = cnt_q;
    data_out_d = data_out_q;
    valid_d    = 1'b0;
    error_d    = 1'b0;

    // A load edge wins over a coincident shift edge; the shift is dropped.
    // Shift edges while LOAD is low are ignored.
    if (load_fall) begin
      ev = EV_LOAD;
    end else if (clk_rise && load_sync) begin
      ev = EV_SHIFT;
    end

    case (ev)
      EV_LOAD: begin
        if (cnt_q == CNT_FULL) begin
          data_out_d = rx_q;
          valid_d    = 1'b1;
        end else if (cnt_q != '0) begin
          error_d = 1'b1;
        end
        tx_d  = data_in;
        cnt_d = '0;
      end
      EV_SHIFT: begin
        rx_d = {rx_q[WIDTH-2:0], din_sync};
        tx_d = {tx_q[WIDTH-2:0], 1'b0};
        // Saturating at WIDTH+1 keeps an overflowed frame distinguishable
        // from a complete one until the next load.
        if (cnt_q != CNT_SAT) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_q       <= '0;
      tx_q       <= '0;
      cnt_q      <= '0;
      data_out_q <= '0;
      valid_q    <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      rx_q       <= rx_d;
      tx_q       <= tx_d;
      cnt_q      <= cnt_d;
      data_out_q <= data_out_d;
      valid_q    <= valid_d;
      error_q    <= error_d;
    end
  end

  // tx_q is a register, so SHIFT_DOUT is glitch-free and tracks its MSB.
  assign link.SHIFT_DOUT = tx_q[WIDTH-1];
  assign data_out        = data_out_q;
  assign frame_valid     = valid_q;
  assign frame_error     = error_q;

endmodule

// File: tb/tb_expansion_shiftreg_target.sv
// Directed bench for expansion_shiftreg_target (WIDTH=8, SYNC_STAGES=2).
// A behavioural master drives the link with a SHIFT_CLK half-period of 6 clk.
module tb_expansion_shiftreg_target;

  localparam int WIDTH = 8;
  localparam int HALF  = 6;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] data_out;
  logic             frame_valid;
  logic             frame_error;

  expansion_shiftreg_target_if bus ();

  expansion_shiftreg_target #(.WIDTH(WIDTH), .SYNC_STAGES(2)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .link        (bus.slave),
    .data_in     (data_in),
    .data_out    (data_out),
    .frame_valid (frame_valid),
    .frame_error (frame_error)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Whole-run pulse tally, so stray pulses outside the load windows are caught.
  int n_valid = 0;
  int n_error = 0;
  int n_both  = 0;
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (frame_valid === 1'b1) n_valid++;
      if (frame_error === 1'b1) n_error++;
      if (frame_valid === 1'b1 && frame_error === 1'b1) n_both++;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Shift n bits (bits[n-1] first). SHIFT_DOUT is sampled just before each
  // rising edge, as the master would.
  task automatic shift_bits(input logic [15:0] bits, input int n, output logic [15:0] samples);
    samples = '0;
    for (int i = n - 1; i >= 0; i--) begin
      bus.SHIFT_CLK = 1'b0;
      bus.SHIFT_DIN = bits[i];
      wait_cycles(HALF);
      samples = {samples[14:0], bus.SHIFT_DOUT};
      bus.SHIFT_CLK = 1'b1;
      wait_cycles(HALF);
    end
  endtask

  // LOAD low for HALF cycles; records the pulse outputs cycle by cycle
  // (index k = k+1 clk edges after the falling edge).
  task automatic do_load(input logic [7:0] word, output logic [5:0] vh, output logic [5:0] eh);
    data_in        = word;
    bus.SHIFT_LOAD = 1'b0;
    for (int k = 0; k < HALF; k++) begin
      @(negedge clk);
      vh[k] = frame_valid;
      eh[k] = frame_error;
    end
    bus.SHIFT_LOAD = 1'b1;
    wait_cycles(HALF);
  endtask

  typedef struct {
    logic [15:0] bits;
    int          nbits;
    logic [7:0]  next_in;
    logic [15:0] exp_samples;
    logic        exp_dout_end;
    logic [5:0]  exp_vh;
    logic [5:0]  exp_eh;
    logic [7:0]  exp_data_out;
  } vec_t;

  vec_t vecs [5];

  task automatic run_vec(input int i);
    logic [15:0] samples;
    logic [5:0]  vh, eh;
    string       tag;
    tag = $sformatf("vec%0d", i);
    shift_bits(vecs[i].bits, vecs[i].nbits, samples);
    check({tag, " dout_samples"}, 32'(samples), 32'(vecs[i].exp_samples));
    check({tag, " dout_end"}, 32'(bus.SHIFT_DOUT), 32'(vecs[i].exp_dout_end));
    do_load(vecs[i].next_in, vh, eh);
    check({tag, " valid_timing"}, 32'(vh), 32'(vecs[i].exp_vh));
    check({tag, " error_timing"}, 32'(eh), 32'(vecs[i].exp_eh));
    check({tag, " data_out"}, 32'(data_out), 32'(vecs[i].exp_data_out));
    check({tag, " dout_after_load"}, 32'(bus.SHIFT_DOUT), 32'(vecs[i].next_in[7]));
  endtask

  initial begin
    logic [15:0] samples;
    logic [5:0]  vh, eh;

    // {bits, nbits, next data_in, DOUT samples, DOUT after shifts,
    //  valid history, error history, data_out}
    vecs[0] = '{16'h00A5, 8, 8'h5B, 16'h0003, 1'b0, 6'b000100, 6'b000000, 8'hA5};
    vecs[1] = '{16'h007F, 7, 8'hC3, 16'h002D, 1'b1, 6'b000000, 6'b000100, 8'hA5};
    vecs[2] = '{16'h0155, 9, 8'h00, 16'h0186, 1'b0, 6'b000000, 6'b000100, 8'hA5};
    vecs[3] = '{16'h003C, 8, 8'h96, 16'h00F0, 1'b0, 6'b000100, 6'b000000, 8'h3C};
    vecs[4] = '{16'h00FF, 8, 8'h00, 16'h0096, 1'b0, 6'b000100, 6'b000000, 8'hFF};

    // Reset with the link idle (LOAD high, CLK low).
    rst_n          = 1'b0;
    bus.SHIFT_CLK  = 1'b0;
    bus.SHIFT_LOAD = 1'b1;
    bus.SHIFT_DIN  = 1'b0;
    data_in        = '0;
    wait_cycles(3);
    check("reset data_out", 32'(data_out), 32'h0);
    check("reset dout", 32'(bus.SHIFT_DOUT), 32'h0);
    check("reset valid", 32'(frame_valid), 32'h0);
    check("reset error", 32'(frame_error), 32'h0);
    rst_n = 1'b1;
    wait_cycles(8);
    check("post-reset pulses", 32'(n_valid + n_error), 32'h0);

    // Opening load with nothing shifted: no pulse, captures 0x03.
    do_load(8'h03, vh, eh);
    check("first load valid", 32'(vh), 32'h0);
    check("first load error", 32'(eh), 32'h0);
    check("first load dout", 32'(bus.SHIFT_DOUT), 32'h0);

    // Good frame, short frame, long frame.
    for (int i = 0; i < 3; i++) run_vec(i);

    // Three SHIFT_CLK rises while LOAD is low must be ignored; the falling
    // LOAD edge follows a clean load so it pulses nothing.
    data_in        = 8'hF0;
    bus.SHIFT_LOAD = 1'b0;
    wait_cycles(HALF);
    for (int t = 0; t < 3; t++) begin
      bus.SHIFT_CLK = 1'b0;
      wait_cycles(HALF);
      bus.SHIFT_CLK = 1'b1;
      wait_cycles(HALF);
    end
    bus.SHIFT_LOAD = 1'b1;
    wait_cycles(HALF);
    check("lowload data_out", 32'(data_out), 32'hA5);
    check("lowload dout", 32'(bus.SHIFT_DOUT), 32'h1);

    // 0x3C must land intact (and SHIFT_DOUT must still start at 0xF0's MSB).
    for (int i = 3; i < 5; i++) run_vec(i);

    // Reset mid-frame: partial frame discarded silently.
    do_load(8'h00, vh, eh);
    check("pre-abort load", 32'({vh, eh}), 32'h0);
    shift_bits(16'h000F, 4, samples);
    rst_n         = 1'b0;
    bus.SHIFT_CLK = 1'b0;
    wait_cycles(3);
    check("abort data_out", 32'(data_out), 32'h0);
    check("abort dout", 32'(bus.SHIFT_DOUT), 32'h0);
    check("abort pulses", 32'({frame_valid, frame_error}), 32'h0);
    rst_n = 1'b1;
    wait_cycles(HALF);
    shift_bits(16'h0081, 8, samples);
    check("after-abort dout_samples", 32'(samples), 32'h0);
    do_load(8'h00, vh, eh);
    check("after-abort valid_timing", 32'(vh), 32'(6'b000100));
    check("after-abort error_timing", 32'(eh), 32'h0);
    check("after-abort data_out", 32'(data_out), 32'h81);

    // Whole-run pulse totals: 4 good frames, 2 bad, never both at once.
    check("total valid pulses", 32'(n_valid), 32'd4);
    check("total error pulses", 32'(n_error), 32'd2);
    check("valid and error together", 32'(n_both), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/expansion_shiftreg_target.md
Name: expansion_shiftreg_target

Overview:
FPGA-side target of the expansion shift-register link. It emulates the external 74HC595/74HC165-style chain that the expansion_shiftreg master drives, so an FPGA can act as an I/O expander for another RIO board. It oversamples SHIFT_CLK, SHIFT_LOAD and SHIFT_DIN in the local clock domain. It deserialises master-to-target bits onto data_out and serialises data_in back to the master.

Parameters:
WIDTH, 8, bits per frame; must be ≥2.
SYNC_STAGES, 2, synchroniser flops per async input; must be ≥2.

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous, active-low
SHIFT_CLK  in  1  shift clock from master, async
SHIFT_LOAD  in  1  load/latch strobe from master, async, idle high
SHIFT_DIN  in  1  serial data from master (master's SHIFT_OUT)
SHIFT_DOUT  out  1  serial data to master (master's SHIFT_IN)
data_in  in  WIDTH  parallel word returned to master; captured at load
data_out  out  WIDTH  last complete word received from master
frame_valid  out  1  one-clk pulse when data_out updates
frame_error  out  1  one-clk pulse on a frame with wrong bit count

Behaviour:
- One clock domain: clk. Reset is asynchronous and active-low (rst_n).
- Reset values:
  - data_out=0, SHIFT_DOUT=0, frame_valid=0, frame_error=0.
  - rx_sr=0, tx_sr=0, bit_cnt=0.
  - Synchronised LOAD resets to 1; synchronised CLK and DIN reset to 0. This prevents a spurious edge after reset.
- Synchronisers: each async input passes through SYNC_STAGES flops. Edge detection compares the last synchronised stage with one extra registered copy.
- Load event (synced SHIFT_LOAD falling edge):
  - If bit_cnt==WIDTH: data_out<=rx_sr and frame_valid=1 for one cycle.
  - Else if bit_cnt!=0: frame_error=1 for one cycle; data_out holds.
  - Else (bit_cnt==0): no pulse.
  - Then tx_sr<=data_in and bit_cnt<=0. All of this happens in the same cycle.
- Shift event (synced SHIFT_CLK rising edge while synced LOAD==1):
  - rx_sr<={rx_sr[WIDTH-2:0], din_sync}, MSB first.
  - tx_sr<={tx_sr[WIDTH-2:0],1'b0}.
  - bit_cnt increments, saturating at WIDTH+1.
  - SHIFT_CLK edges while LOAD is low are ignored.
- SHIFT_DOUT is registered and always equals tx_sr[WIDTH-1]. The MSB of data_in is presented after load; each following bit is presented after each shift edge.
- Latency: async edge to internal action or SHIFT_DOUT change is SYNC_STAGES+1 clk cycles.
- Master timing requirement: SHIFT_CLK high and low times, and the LOAD low time, must each be ≥ SYNC_STAGES+2 clk cycles. The master samples SHIFT_DOUT no earlier than its next SHIFT_CLK rising edge.
- DIN sampling: din_sync is taken from the same synchroniser depth as CLK. The bit sampled is the value DIN held at the master's rising edge.
- Simultaneous load edge and shift edge: the load wins and the shift is dropped. Such an edge is illegal from the master and is not counted.
- Overflow: more than WIDTH shift edges saturates bit_cnt at WIDTH+1. rx_sr holds the last WIDTH bits. The next load flags frame_error.
- Reset asserted mid-frame: all state clears immediately. The partial frame is discarded silently, with no error pulse.
- frame_valid and frame_error are never high together.

Decomposition:
- Shared package expansion_shiftreg_pkg holds:
  - default WIDTH;
  - SYNC_STAGES default;
  - bit_cnt width constant $clog2(WIDTH+2).
  Both master and target use it.
- Sub-module shiftreg_sync_edge holds the parameterised synchroniser, rising/falling edge detect and reset value. It is instantiated three times: CLK, LOAD and DIN (DIN ignores its edge outputs).

Test Plan:
Bench master uses a SHIFT_CLK half-period of 6 clk and WIDTH=8.
1. Reset → data_out=0x00, SHIFT_DOUT=0, no pulses. Release rst_n with LOAD high → no frame_error.
2. Load, 8 clocks shifting DIN=0xA5 MSB first, then load → data_out=0xA5; frame_valid high exactly 1 cycle, SYNC_STAGES+1 cycles after the LOAD falling edge.
3. data_in=0x03 at load, 8 clocks → master samples SHIFT_DOUT as 0,0,0,0,0,0,1,1 (0x03); after 8 shifts SHIFT_DOUT=0.
4. After step 2, send 7 clocks of 0xFF then load → frame_error one cycle; data_out stays 0xA5. Then 9 clocks then load → frame_error; data_out stays 0xA5.
5. SHIFT_CLK toggled 3 times while LOAD is low, then 8 clocks of 0x3C, then load → data_out=0x3C and frame_valid (the low-LOAD clocks are ignored).
6. Pulse rst_n low after 4 of 8 clocks → data_out=0, no pulses. Next full frame of 0x81 → data_out=0x81 with frame_valid.
